// File: rtl/fifo_consumer.sv
// Burst-oriented drain of an upstream FIFO onto a valid/ready stream.
// It pops whole bursts only when the FIFO already holds them, and it marks the last word of each job.
module fifo_consumer #(
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  total_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic [CW-1:0]     fifo_count_i,
  output logic              fifo_rd_en_o,
  input  logic [DATA_W-1:0] fifo_rdata_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  input  logic              out_ready_i,
  output logic [5:0]        dbg_state_o
);

  localparam int BW = $clog2(BURST_LEN + 1);

  // One-hot state bit positions; dbg_state_o exposes the raw vector.
  localparam int S_IDLE   = 0;
  localparam int S_WAIT   = 1;
  localparam int S_BURST  = 2;
  localparam int S_BDONE  = 3;
  localparam int S_BNDONE = 4;
  localparam int S_DONE   = 5;

  localparam logic [5:0] ST_IDLE   = 6'b000001;
  localparam logic [5:0] ST_WAIT   = 6'b000010;
  localparam logic [5:0] ST_BURST  = 6'b000100;
  localparam logic [5:0] ST_BDONE  = 6'b001000;
  localparam logic [5:0] ST_BNDONE = 6'b010000;
  localparam logic [5:0] ST_DONE   = 6'b100000;

  logic [5:0]        r_state;
  logic [5:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_rem;
  logic [BW-1:0]     r_bcnt;
  logic [BW-1:0]     r_bsz;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_skid_last;

  logic [BW-1:0]     w_bsz_nxt;
  logic              w_wait_ok;
  logic              w_pop_out;
  logic [1:0]        w_occ;
  logic              w_credit;
  logic              w_rd_en;
  logic              w_burst_end;
  logic              w_drained;

  assign w_bsz_nxt   = (r_rem > CNT_W'(BURST_LEN)) ? BW'(BURST_LEN) : BW'(r_rem);
  assign w_wait_ok   = (32'(fifo_count_i) >= 32'(w_bsz_nxt));
  assign w_pop_out   = r_out_valid & out_ready_i;
  assign w_occ       = {1'b0, r_out_valid} + {1'b0, r_skid_valid} + {1'b0, r_inflight};
  // A word popped now lands in the buffer next cycle; never let buffer plus flight exceed two.
  assign w_credit    = (w_occ < (2'd2 + {1'b0, w_pop_out}));
  assign w_rd_en     = r_state[S_BURST] & (r_bcnt < r_bsz) & w_credit;
  assign w_burst_end = ((r_bcnt + BW'(1)) == r_bsz);
  assign w_drained   = ~r_out_valid & ~r_skid_valid & ~r_inflight;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state[S_IDLE]) begin
      if (start_i) w_state_nxt = (total_i == '0) ? ST_DONE : ST_WAIT;
    end else if (r_state[S_WAIT]) begin
      if (w_wait_ok) w_state_nxt = ST_BURST;
    end else if (r_state[S_BURST]) begin
      if (w_rd_en && w_burst_end) w_state_nxt = (r_rem == CNT_W'(1)) ? ST_BDONE : ST_BNDONE;
    end else if (r_state[S_BNDONE]) begin
      w_state_nxt = ST_WAIT;
    end else if (r_state[S_BDONE]) begin
      if (w_drained) w_state_nxt = ST_DONE;
    end else begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_comb begin
    busy_o       = ~r_state[S_IDLE];
    done_o       = r_state[S_DONE];
    fifo_rd_en_o = w_rd_en;
    out_valid_o  = r_out_valid;
    out_data_o   = r_out_data;
    out_last_o   = r_out_valid & r_out_last;
    dbg_state_o  = r_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_bcnt <= '0;
      r_bsz  <= '0;
    end else begin
      if (r_state[S_IDLE] && start_i) r_rem <= total_i;
      if (r_state[S_WAIT] && w_wait_ok) begin
        r_bsz  <= w_bsz_nxt;
        r_bcnt <= '0;
      end
      if (w_rd_en) begin
        r_rem  <= r_rem - CNT_W'(1);
        r_bcnt <= r_bcnt + BW'(1);
      end
      if (r_state[S_BNDONE] || r_state[S_DONE]) r_bcnt <= '0;
    end
  end

  // Output register plus skid; the skid only fills while the output register is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_out_valid     <= 1'b0;
      r_out_data      <= '0;
      r_out_last      <= 1'b0;
      r_skid_valid    <= 1'b0;
      r_skid_data     <= '0;
      r_skid_last     <= 1'b0;
    end else begin
      r_inflight      <= w_rd_en;
      r_inflight_last <= w_rd_en & (r_rem == CNT_W'(1));
      if (w_pop_out) begin
        if (r_skid_valid) begin
          r_out_data  <= r_skid_data;
          r_out_last  <= r_skid_last;
          r_out_valid <= 1'b1;
          if (r_inflight) begin
            r_skid_data <= fifo_rdata_i;
            r_skid_last <= r_inflight_last;
          end else begin
            r_skid_valid <= 1'b0;
            r_skid_last  <= 1'b0;
          end
        end else if (r_inflight) begin
          r_out_data  <= fifo_rdata_i;
          r_out_last  <= r_inflight_last;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
      end else if (r_inflight) begin
        if (!r_out_valid) begin
          r_out_data  <= fifo_rdata_i;
          r_out_last  <= r_inflight_last;
          r_out_valid <= 1'b1;
        end else begin
          r_skid_data  <= fifo_rdata_i;
          r_skid_last  <= r_inflight_last;
          r_skid_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_consumer.sv
// Bench for fifo_consumer: a queue-based FIFO/producer model, a scoreboard of produced words,
// table-driven jobs, a mid-burst reset sequence and randomized jobs.
module tb_fifo_consumer;

  localparam int DATA_W     = 32;
  localparam int CNT_W      = 16;
  localparam int BURST_LEN  = 16;
  localparam int FIFO_DEPTH = 32;
  localparam int CW         = $clog2(FIFO_DEPTH + 1);
  localparam int MAX_CYC    = 3000;

  localparam logic [5:0] ST_IDLE   = 6'b000001;
  localparam logic [5:0] ST_BNDONE = 6'b010000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic [CNT_W-1:0]  total_i = '0;
  logic              busy_o;
  logic              done_o;
  logic [CW-1:0]     fifo_count_i = '0;
  logic              fifo_rd_en_o;
  logic [DATA_W-1:0] fifo_rdata_i = '0;
  logic              out_valid_o;
  logic [DATA_W-1:0] out_data_o;
  logic              out_last_o;
  logic              out_ready_i = 1'b0;
  logic [5:0]        dbg_state_o;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] fifo_q[$];
  int n_checks = 0;
  int n_errors = 0;

  fifo_consumer #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .total_i(total_i),
    .busy_o(busy_o), .done_o(done_o), .fifo_count_i(fifo_count_i),
    .fifo_rd_en_o(fifo_rd_en_o), .fifo_rdata_i(fifo_rdata_i),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_last_o(out_last_o),
    .out_ready_i(out_ready_i), .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic push_word();
    logic [DATA_W-1:0] w;
    w = $urandom;
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // Runs one job: fill = 0 prefills the FIFO then refills 1/cycle, fill = N refills one word every N cycles.
  task automatic run_job(input string name, input int total, input int fill, input int ready_pct,
                         input int mid_start, input bit exp_contig, input int exp_ndone);
    int produced = 0, beats = 0, pops = 0, done_cnt = 0, ndone_cnt = 0, busy_cyc = 0;
    int cyc = 0, done_cyc = -1, burst_pops = 0, burst_sz = 0, rem = total, period;
    int first_rd = -1, last_rd = -1, first_bt = -1, last_bt = -1;
    bit pend_pop = 0, prev_stall = 0, finished = 0;
    logic [DATA_W-1:0] prev_data = '0;
    logic [DATA_W-1:0] w;
    exp_q.delete();
    fifo_q.delete();
    period = (fill == 0) ? 1 : fill;
    if (fill == 0) begin
      while (produced < min_i(total, FIFO_DEPTH)) begin
        push_word();
        produced++;
      end
    end
    while (!finished && cyc < MAX_CYC) begin
      @(posedge clk); #1;
      if (pend_pop && fifo_q.size() > 0) fifo_rdata_i = fifo_q.pop_front();
      else fifo_rdata_i = $urandom;
      if (produced < total && fifo_q.size() < FIFO_DEPTH && (cyc % period) == 0) begin
        push_word();
        produced++;
      end
      fifo_count_i = CW'(fifo_q.size());
      start_i = (cyc == 0) || (cyc == mid_start);
      total_i = (cyc == 0) ? CNT_W'(total) : CNT_W'($urandom_range(1, 100));
      out_ready_i = ($urandom_range(0, 99) < ready_pct);
      @(negedge clk);
      if (busy_o) busy_cyc++;
      pend_pop = fifo_rd_en_o;
      if (fifo_rd_en_o) begin
        chk({name, ":rd_nonempty"}, 64'(fifo_q.size() > 0), 64'(1));
        if (burst_pops == 0) begin
          burst_sz = min_i(BURST_LEN, rem);
          chk({name, ":wait_gate"}, 64'(fifo_q.size() >= burst_sz), 64'(1));
        end
        burst_pops++;
        pops++;
        rem--;
        chk({name, ":burst_bound"}, 64'(burst_pops <= burst_sz), 64'(1));
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
      end
      if (dbg_state_o == ST_BNDONE) begin
        ndone_cnt++;
        chk({name, ":burst_size"}, 64'(burst_pops), 64'(burst_sz));
        burst_pops = 0;
      end
      if (prev_stall) begin
        chk({name, ":stall_valid"}, 64'(out_valid_o), 64'(1));
        chk({name, ":stall_data"}, 64'(out_data_o), 64'(prev_data));
      end
      if (!out_valid_o) chk({name, ":last_novalid"}, 64'(out_last_o), 64'(0));
      if (out_valid_o && out_ready_i) begin
        w = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk({name, ":data"}, 64'(out_data_o), 64'(w));
        chk({name, ":last"}, 64'(out_last_o), 64'(beats == total - 1));
        beats++;
        if (first_bt < 0) first_bt = cyc;
        last_bt = cyc;
      end
      chk({name, ":outstanding"}, 64'((pops - beats) <= 2), 64'(1));
      prev_stall = out_valid_o && !out_ready_i;
      prev_data  = out_data_o;
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        chk({name, ":done_after_last"}, 64'(beats), 64'(total));
      end else if (done_cnt > 0 && cyc == done_cyc + 1) begin
        chk({name, ":idle_busy"}, 64'(busy_o), 64'(0));
        chk({name, ":idle_state"}, 64'(dbg_state_o), 64'(ST_IDLE));
        finished = 1;
      end
      cyc++;
    end
    start_i = 1'b0;
    chk({name, ":finished_in_budget"}, 64'(finished), 64'(1));
    chk({name, ":beats"}, 64'(beats), 64'(total));
    chk({name, ":pops"}, 64'(pops), 64'(total));
    chk({name, ":done_count"}, 64'(done_cnt), 64'(1));
    chk({name, ":ndone_count"}, 64'(ndone_cnt), 64'(exp_ndone));
    chk({name, ":scoreboard_empty"}, 64'(exp_q.size()), 64'(0));
    if (exp_contig) begin
      chk({name, ":rd_contig"}, 64'(last_rd - first_rd + 1), 64'(total));
      chk({name, ":beat_contig"}, 64'(last_bt - first_bt + 1), 64'(total));
    end
    if (total == 0) begin
      chk({name, ":zero_busy_cycles"}, 64'(busy_cyc), 64'(1));
      chk({name, ":zero_done_cycle"}, 64'(done_cyc), 64'(1));
    end
  endtask

  typedef struct {
    string name;
    int    total;
    int    fill;
    int    ready_pct;
    int    mid_start;
    bit    exp_contig;
    int    exp_ndone;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int pops;
    int total;
    tbl[0] = '{"t5_single", 5, 0, 100, -1, 1'b1, 0};
    tbl[1] = '{"t40_slow", 40, 3, 100, -1, 1'b0, 2};
    tbl[2] = '{"t20_stall", 20, 0, 50, -1, 1'b0, 1};
    tbl[3] = '{"t0_empty", 0, 0, 100, -1, 1'b0, 0};
    tbl[4] = '{"t12_restart", 12, 0, 100, 5, 1'b0, 0};
    tbl[5] = '{"t16_exact", 16, 0, 100, -1, 1'b1, 0};
    tbl[6] = '{"t17_split", 17, 1, 70, -1, 1'b0, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 64'(busy_o), 64'(0));
    chk("reset_valid", 64'(out_valid_o), 64'(0));
    chk("reset_rd_en", 64'(fifo_rd_en_o), 64'(0));
    chk("reset_state", 64'(dbg_state_o), 64'(ST_IDLE));
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_job(tbl[i].name, tbl[i].total, tbl[i].fill, tbl[i].ready_pct,
              tbl[i].mid_start, tbl[i].exp_contig, tbl[i].exp_ndone);

    // Mid-burst reset with the output buffer full and the consumer stalled.
    pops = 0;
    @(posedge clk); #1;
    fifo_count_i = CW'(10);
    total_i = CNT_W'(10);
    start_i = 1'b1;
    out_ready_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int c = 0; c < 12; c++) begin
      fifo_rdata_i = $urandom;
      @(negedge clk);
      if (fifo_rd_en_o) pops++;
      @(posedge clk); #1;
    end
    chk("rst_credit_pops", 64'(pops), 64'(2));
    chk("rst_pre_valid", 64'(out_valid_o), 64'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    chk("rst_rd_en", 64'(fifo_rd_en_o), 64'(0));
    chk("rst_valid", 64'(out_valid_o), 64'(0));
    chk("rst_data", 64'(out_data_o), 64'(0));
    chk("rst_last", 64'(out_last_o), 64'(0));
    chk("rst_state", 64'(dbg_state_o), 64'(ST_IDLE));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fifo_count_i = '0;
    run_job("t3_after_reset", 3, 0, 100, -1, 1'b1, 0);

    for (int j = 0; j < 6; j++) begin
      total = $urandom_range(1, 45);
      run_job($sformatf("rand%0d", j), total, $urandom_range(0, 3), $urandom_range(30, 100),
              -1, 1'b0, (total + BURST_LEN - 1) / BURST_LEN - 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
